// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared opcode/funct3 encodings and fetch FSM state type for the PC control block.
// No logic; constants only.
package fetch_pc_ctrl_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Execute-stage resolve inputs and fetch-side outputs of fetch_pc_ctrl.
// Stats outputs exist only when BRANCH_STATS_EN is defined.
interface fetch_pc_ctrl_if #(parameter int AWIDTH = 32);

    logic              ex_valid_i;
    logic [6:0]        opcode_i;
    logic [2:0]        funct3_i;
    logic              breq_i;
    logic              brlt_i;
    logic              brltu_i;
    logic [AWIDTH-1:0] target_i;
    logic              imem_ready_i;
    logic              stall_i;
    logic [AWIDTH-1:0] pc_o;
    logic              pc_valid_o;
    logic              taken_o;
    logic              redirect_o;
    logic              flush_o;
`ifdef BRANCH_STATS_EN
    logic [31:0]       br_cnt_o;
    logic [31:0]       br_taken_cnt_o;
`endif

    modport master (
        output ex_valid_i, opcode_i, funct3_i, breq_i, brlt_i, brltu_i,
               target_i, imem_ready_i, stall_i,
        input  pc_o, pc_valid_o, taken_o, redirect_o, flush_o
`ifdef BRANCH_STATS_EN
        , br_cnt_o, br_taken_cnt_o
`endif
    );

    modport slave (
        input  ex_valid_i, opcode_i, funct3_i, breq_i, brlt_i, brltu_i,
               target_i, imem_ready_i, stall_i,
        output pc_o, pc_valid_o, taken_o, redirect_o, flush_o
`ifdef BRANCH_STATS_EN
        , br_cnt_o, br_taken_cnt_o
`endif
    );

endinterface

// File: rtl/fetch_pc_ctrl_branch_taken_dec.sv
// Taken decode for BRANCH/JAL/JALR from opcode, funct3 and comparator flags.
// Latency: combinational. Backpressure: none.
module branch_taken_dec
    import fetch_pc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       breq,
    input  logic       brlt,
    input  logic       brltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_JAL, OP_JALR: taken = 1'b1;
            OP_BRANCH: begin
                case (funct3)
                    F3_BEQ:  taken = breq;
                    F3_BNE:  taken = !breq;
                    F3_BLT:  taken = brlt;
                    F3_BGE:  taken = !brlt;
                    F3_BLTU: taken = brltu;
                    F3_BGEU: taken = !brltu;
                    default: taken = 1'b0;
                endcase
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// PC register + redirect/flush control; BRANCH_STATS_EN adds branch/taken counters.
// Latency: resolve in cycle N -> pc_o/redirect_o/flush_o updated in N+1.
// Backpressure: imem_ready_i/stall_i hold the PC; a taken redirect always wins.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int                AWIDTH       = 32,
    parameter logic [AWIDTH-1:0] BASEADDR     = AWIDTH'(32'h0100_0000),
    parameter int                FLUSH_CYCLES = 2
)(
    input  logic           clk,
    input  logic           reset,
    fetch_pc_ctrl_if.slave bus
);

    localparam logic [1:0] S_BOOT  = BOOT;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_FLUSH = FLUSH;
    localparam logic [2:0] CNT_LAST = 3'(FLUSH_CYCLES - 1);

    logic [1:0]        state_q;
    logic [2:0]        cnt_q;
    logic [AWIDTH-1:0] pc_q;
    logic              redirect_q;
    logic              dec_taken;
    logic              taken;
    logic              advance;

    branch_taken_dec u_dec (
        .opcode (bus.opcode_i),
        .funct3 (bus.funct3_i),
        .breq   (bus.breq_i),
        .brlt   (bus.brlt_i),
        .brltu  (bus.brltu_i),
        .taken  (dec_taken)
    );

    // Instructions in execute during FLUSH are already squashed, so they never resolve.
    assign taken   = bus.ex_valid_i && (state_q != S_FLUSH) && dec_taken;
    assign advance = (state_q != S_BOOT) && bus.imem_ready_i && !bus.stall_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_BOOT;
            cnt_q      <= 3'd0;
            pc_q       <= BASEADDR;
            redirect_q <= 1'b0;
        end else begin
            redirect_q <= taken;
            if (taken) begin
                pc_q    <= (bus.opcode_i == OP_JALR) ? {bus.target_i[AWIDTH-1:1], 1'b0}
                                                      : bus.target_i;
                cnt_q   <= 3'd0;
                state_q <= S_FLUSH;
            end else begin
                if (advance)
                    pc_q <= pc_q + AWIDTH'(4);
                case (state_q)
                    S_BOOT:  state_q <= S_RUN;
                    S_RUN:   state_q <= S_RUN;
                    S_FLUSH: begin
                        if (cnt_q == CNT_LAST)
                            state_q <= S_RUN;
                        else
                            cnt_q <= cnt_q + 3'd1;
                    end
                    default: state_q <= S_RUN;
                endcase
            end
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = (state_q != S_BOOT);
    assign bus.taken_o    = taken;
    assign bus.redirect_o = redirect_q;
    assign bus.flush_o    = (state_q == S_FLUSH);

`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] br_taken_cnt_q;
    logic        br_resolved;

    assign br_resolved = bus.ex_valid_i && (state_q != S_FLUSH) && (bus.opcode_i == OP_BRANCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q       <= 32'd0;
            br_taken_cnt_q <= 32'd0;
        end else begin
            if (br_resolved && (br_cnt_q != 32'hFFFF_FFFF))
                br_cnt_q <= br_cnt_q + 32'd1;
            if (br_resolved && dec_taken && (br_taken_cnt_q != 32'hFFFF_FFFF))
                br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
        end
    end

    assign bus.br_cnt_o       = br_cnt_q;
    assign bus.br_taken_cnt_o = br_taken_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed + random stimulus for fetch_pc_ctrl against a cycle-level reference model.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam int          FC   = 2;
    localparam logic [6:0]  BR   = 7'b1100011;
    localparam logic [6:0]  JAL  = 7'b1101111;
    localparam logic [6:0]  JALR = 7'b1100111;
    localparam logic [6:0]  ALU  = 7'b0110011;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_pc_ctrl_if #(.AWIDTH(32)) bus ();

    fetch_pc_ctrl #(.AWIDTH(32), .BASEADDR(BASE), .FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: PC value, whether the boot cycle has passed, flush cycles remaining.
    logic [31:0] m_pc;
    bit          m_booted;
    int          m_flush_left;
    bit          m_redirect;
    logic [31:0] m_br;
    logic [31:0] m_brt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_taken(input bit v, input logic [6:0] op, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
        if (!v || m_flush_left > 0) return 1'b0;
        if (op == JAL || op == JALR) return 1'b1;
        if (op != BR) return 1'b0;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = BASE; m_booted = 1'b0; m_flush_left = 0; m_redirect = 1'b0;
        m_br = 32'd0; m_brt = 32'd0;
    endtask

    task automatic step(input bit rst, input bit v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                        input bit rdy, input bit stl);
        bit exp_taken;
        reset            = rst;
        bus.ex_valid_i   = v;
        bus.opcode_i     = op;
        bus.funct3_i     = f3;
        bus.breq_i       = (a == b);
        bus.brlt_i       = ($signed(a) < $signed(b));
        bus.brltu_i      = (a < b);
        bus.target_i     = tgt;
        bus.imem_ready_i = rdy;
        bus.stall_i      = stl;
        @(negedge clk);
        exp_taken = ref_taken(v, op, f3, a, b);
        chk("taken",    {31'd0, bus.taken_o},    {31'd0, exp_taken});
        chk("pc",       bus.pc_o,                m_pc);
        chk("pc_valid", {31'd0, bus.pc_valid_o}, {31'd0, m_booted});
        chk("redirect", {31'd0, bus.redirect_o}, {31'd0, m_redirect});
        chk("flush",    {31'd0, bus.flush_o},    {31'd0, m_flush_left > 0});
`ifdef BRANCH_STATS_EN
        chk("br_cnt",       bus.br_cnt_o,       m_br);
        chk("br_taken_cnt", bus.br_taken_cnt_o, m_brt);
`endif
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (v && m_flush_left == 0 && op == BR) begin
                if (m_br != 32'hFFFF_FFFF) m_br++;
                if (exp_taken && m_brt != 32'hFFFF_FFFF) m_brt++;
            end
            if (exp_taken) begin
                m_pc         = (op == JALR) ? (tgt & 32'hFFFF_FFFE) : tgt;
                m_redirect   = 1'b1;
                m_flush_left = FC;
            end else begin
                m_redirect = 1'b0;
                if (m_flush_left > 0) m_flush_left--;
                if (m_booted && rdy && !stl) m_pc = m_pc + 32'd4;
            end
            m_booted = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, ALU, 3'd0, 32'd0, 32'd1, 32'd0, rdy, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.ex_valid_i = 1'b0; bus.opcode_i = ALU; bus.funct3_i = 3'd0;
        bus.breq_i = 1'b0; bus.brlt_i = 1'b0; bus.brltu_i = 1'b0;
        bus.target_i = 32'd0; bus.imem_ready_i = 1'b1; bus.stall_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_pc",       bus.pc_o, BASE);
        chk("rst_valid",    {31'd0, bus.pc_valid_o}, 32'd0);
        chk("rst_flush",    {31'd0, bus.flush_o},    32'd0);
        chk("rst_redirect", {31'd0, bus.redirect_o}, 32'd0);

        // Boot then sequential fetch: the first valid PC is BASEADDR.
        idle(1'b1);
        chk("boot_pc0", bus.pc_o, 32'h0100_0000);
        idle(1'b1);
        chk("boot_pc1", bus.pc_o, 32'h0100_0004);
        idle(1'b1);
        chk("boot_pc2", bus.pc_o, 32'h0100_0008);

        // BEQ taken, then a JAL arriving during the flush window must be ignored.
        step(1'b0, 1'b1, BR, 3'd0, 32'd7, 32'd7, 32'h0100_0040, 1'b1, 1'b0);
        chk("beq_pc", bus.pc_o, 32'h0100_0040);
        chk("beq_redirect", {31'd0, bus.redirect_o}, 32'd1);
        step(1'b0, 1'b1, JAL, 3'd0, 32'd0, 32'd0, 32'h0200_0000, 1'b1, 1'b0);
        chk("flush_ignore_pc", bus.pc_o, 32'h0100_0044);
        idle(1'b1);
        chk("flush_end", {31'd0, bus.flush_o}, 32'd0);

        // BLTU where signed-less but unsigned-greater: not taken. BGE with rs1>rs2: taken.
        step(1'b0, 1'b1, BR, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h0100_0200, 1'b1, 1'b0);
        step(1'b0, 1'b1, BR, 3'd5, 32'd5, 32'd3, 32'h0100_0100, 1'b1, 1'b0);
        chk("bge_pc", bus.pc_o, 32'h0100_0100);
        idle(1'b1);
        idle(1'b1);

        // JALR with stall and no imem ready: redirect still taken, bit0 cleared.
        step(1'b0, 1'b1, JALR, 3'd0, 32'd0, 32'd0, 32'h0100_0023, 1'b0, 1'b1);
        chk("jalr_pc", bus.pc_o, 32'h0100_0022);
        idle(1'b0);
        idle(1'b1);

        // Wrap-around of the PC.
        step(1'b0, 1'b1, JAL, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        chk("wrap_pre", bus.pc_o, 32'hFFFF_FFFC);
        idle(1'b1);
        chk("wrap_post", bus.pc_o, 32'h0000_0000);
        idle(1'b1);

        // Reset during FLUSH.
        step(1'b0, 1'b1, BR, 3'd1, 32'd1, 32'd2, 32'h0100_0400, 1'b1, 1'b0);
        step(1'b1, 1'b0, ALU, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("rst_flush_pc", bus.pc_o, BASE);
        chk("rst_flush_flush", {31'd0, bus.flush_o}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("rst_flush_stats", bus.br_cnt_o, 32'd0);
`endif

        // Random phase.
        for (int i = 0; i < 600; i++) begin
            logic [6:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            case ($urandom_range(0, 4))
                0, 1:    op = BR;
                2:       op = JAL;
                3:       op = JALR;
                default: op = ALU;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, op,
                 3'($urandom_range(0, 7)), a, b, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
